// File: rtl/conv_1x1_weight_streamer_if.sv
// Memory read port and weight stream port of the 1x1 conv weight streamer.
// The master modport is the streamer side.
interface conv_1x1_weight_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  weight_ready;
  logic                  weight_valid;
  logic [DATA_WIDTH-1:0] weight_out;

  modport master (
    output mem_rd_en, mem_addr, weight_valid, weight_out,
    input  mem_rdata, weight_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, weight_valid, weight_out,
    output mem_rdata, weight_ready
  );
endinterface

// File: rtl/conv_1x1_weight_streamer.sv
// Streams CHANNEL_NUM_IN weights of one output channel per load request from a
// 1-cycle-latency weight memory through a 4-entry credit-controlled FIFO.
module conv_1x1_weight_streamer #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_req,
  conv_1x1_weight_streamer_if.master  bus,
  output logic                        busy,
  output logic                        ch_done,
  output logic                        all_done,
  output logic                        req_overrun
);
  localparam int IC_W       = $clog2(CHANNEL_NUM_IN + 1);
  localparam int OC_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int FIFO_DEPTH = 4;

  localparam logic [IC_W-1:0] IC_END  = IC_W'(CHANNEL_NUM_IN);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(CHANNEL_NUM_IN - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(CHANNEL_NUM_OUT - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                 state_q, state_d;
  logic [OC_W-1:0]        oc_q, oc_d;
  logic [IC_W-1:0]        ic_issue_q, ic_issue_d;
  logic [IC_W-1:0]        ic_sent_q, ic_sent_d;
  logic [ADDR_WIDTH-1:0]  base_addr_q, base_addr_d;
  logic                   inflight_q, inflight_d;
  logic                   ch_done_q, ch_done_d;
  logic                   all_done_q, all_done_d;
  logic                   overrun_q, overrun_d;
  logic [1:0]             wr_ptr_q, wr_ptr_d;
  logic [1:0]             rd_ptr_q, rd_ptr_d;
  logic [2:0]             count_q, count_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;

  logic issue;
  logic push;
  logic pop;
  logic fifo_valid;

  // Credit rule: entries held plus the read in flight never exceed 2 before a
  // new issue, so the FIFO can absorb every returning word without overflow.
  always_comb begin
    fifo_valid = (count_q != 3'd0);
    pop        = fifo_valid && bus.weight_ready;
    push       = inflight_q;
    issue      = (state_q == S_STREAM) && (ic_issue_q < IC_END) &&
                 ((count_q + 3'(inflight_q)) <= 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    oc_d        = oc_q;
    ic_issue_d  = ic_issue_q;
    ic_sent_d   = ic_sent_q;
    base_addr_d = base_addr_q;
    inflight_d  = issue;
    ch_done_d   = 1'b0;
    all_done_d  = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          // The ch_done cycle still belongs to the finishing channel.
          if (ch_done_q) begin
            overrun_d = 1'b1;
          end else begin
            state_d    = S_STREAM;
            ic_issue_d = '0;
            ic_sent_d  = '0;
          end
        end
      end
      S_STREAM: begin
        if (load_req) begin
          overrun_d = 1'b1;
        end
        if (issue) begin
          ic_issue_d = ic_issue_q + IC_W'(1);
        end
        if (pop) begin
          ic_sent_d = ic_sent_q + IC_W'(1);
          if (ic_sent_q == IC_LAST) begin
            state_d   = S_IDLE;
            ch_done_d = 1'b1;
            if (oc_q == OC_LAST) begin
              oc_d        = '0;
              base_addr_d = '0;
              all_done_d  = 1'b1;
            end else begin
              oc_d        = oc_q + OC_W'(1);
              base_addr_d = base_addr_q + ADDR_WIDTH'(CHANNEL_NUM_IN);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      oc_q        <= '0;
      ic_issue_q  <= '0;
      ic_sent_q   <= '0;
      base_addr_q <= '0;
      inflight_q  <= 1'b0;
      ch_done_q   <= 1'b0;
      all_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_q      <= '0;
    end else begin
      state_q     <= state_d;
      oc_q        <= oc_d;
      ic_issue_q  <= ic_issue_d;
      ic_sent_q   <= ic_sent_d;
      base_addr_q <= base_addr_d;
      inflight_q  <= inflight_d;
      ch_done_q   <= ch_done_d;
      all_done_q  <= all_done_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  // Address and data are forced to zero when not qualified so idle outputs stay clean.
  always_comb begin
    bus.mem_rd_en    = issue;
    bus.mem_addr     = issue ? (base_addr_q + ADDR_WIDTH'(ic_issue_q)) : '0;
    bus.weight_valid = fifo_valid;
    bus.weight_out   = fifo_valid ? fifo_q[rd_ptr_q] : '0;
    busy             = (state_q == S_STREAM);
    ch_done          = ch_done_q;
    all_done         = all_done_q;
    req_overrun      = overrun_q;
  end
endmodule

// File: tb/tb_conv_1x1_weight_streamer.sv
// Bench for conv_1x1_weight_streamer: cycle table, degenerate N=1 sequence,
// hand-written corner sequences and a random run checked by a queue model.
module tb_conv_1x1_weight_streamer;
  localparam int N4   = 4;
  localparam int OUT4 = 2;

  logic clk;
  logic rst_n;
  logic load4, load1;
  logic busy4, done4, all4, ovr4;
  logic busy1, done1, all1, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  conv_1x1_weight_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus4 ();
  conv_1x1_weight_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus1 ();

  conv_1x1_weight_streamer #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(N4), .CHANNEL_NUM_OUT(OUT4), .ADDR_WIDTH(8)
  ) dut4 (
    .clk(clk), .reset(rst_n), .load_req(load4), .bus(bus4),
    .busy(busy4), .ch_done(done4), .all_done(all4), .req_overrun(ovr4)
  );

  conv_1x1_weight_streamer #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2), .ADDR_WIDTH(8)
  ) dut1 (
    .clk(clk), .reset(rst_n), .load_req(load1), .bus(bus1),
    .busy(busy1), .ch_done(done1), .all_done(all1), .req_overrun(ovr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b ^ 8'hA5, b, ~b, b};
  endfunction

  // Weight memories: one-cycle registered read.
  initial begin
    bus4.mem_rdata = '0;
    bus1.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus4.mem_rd_en) bus4.mem_rdata <= word_of(int'(bus4.mem_addr));
      if (bus1.mem_rd_en) bus1.mem_rdata <= word_of(int'(bus1.mem_addr));
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    n_checks++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at most %0d at %0t", name, act, lim, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut4: queues of expected addresses and words per accepted request.
  bit          mon_en = 0;
  int          addr_q[$];
  logic [31:0] word_q[$];
  int          m_oc = 0;
  bit          m_active = 0, m_done_now = 0, m_all_now = 0, m_ovr = 0, m_after_rst = 0;
  int          outstanding = 0, issued_cnt = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_word;

  initial begin
    bit          nx_active, nx_done, nx_all;
    int          nx_oc;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        nx_active = m_active; nx_done = 1'b0; nx_all = 1'b0; nx_oc = m_oc;
        chk1("busy", busy4, m_active);
        chk1("ch_done", done4, m_done_now);
        chk1("all_done", all4, m_all_now);
        chk1("req_overrun", ovr4, m_ovr);
        if (m_after_rst) begin
          chk1("rst_rd_en", bus4.mem_rd_en, 1'b0);
          chk1("rst_valid", bus4.weight_valid, 1'b0);
          chk32("rst_addr", 32'(bus4.mem_addr), 32'd0);
          chk32("rst_wout", bus4.weight_out, 32'd0);
          m_after_rst = 0;
        end
        if (bus4.mem_rd_en) begin
          chk_le("spurious_rd", 1, addr_q.size());
          if (addr_q.size() > 0) chk32("mem_addr", 32'(bus4.mem_addr), addr_q.pop_front());
          outstanding++;
          issued_cnt++;
          chk_le("occupancy", outstanding, 4);
        end
        if (stall_prev) begin
          chk1("stall_valid", bus4.weight_valid, 1'b1);
          chk32("stall_word", bus4.weight_out, stall_word);
        end
        stall_prev = bus4.weight_valid && !bus4.weight_ready;
        stall_word = bus4.weight_out;
        if (bus4.weight_valid && bus4.weight_ready) begin
          chk_le("spurious_xfer", 1, word_q.size());
          if (word_q.size() > 0) begin
            w = word_q.pop_front();
            chk32("weight_out", bus4.weight_out, w);
            if (word_q.size() == 0) begin
              nx_active = 1'b0;
              nx_done   = 1'b1;
              nx_all    = (m_oc == OUT4 - 1);
              nx_oc     = (m_oc == OUT4 - 1) ? 0 : m_oc + 1;
            end
          end
          outstanding--;
        end
        if (!rst_n) begin
          addr_q.delete(); word_q.delete();
          m_oc = 0; m_active = 0; m_done_now = 0; m_all_now = 0; m_ovr = 0;
          outstanding = 0; stall_prev = 0; m_after_rst = 1;
        end else begin
          if (load4) begin
            if (m_active || m_done_now) begin
              m_ovr = 1;
            end else begin
              for (int i = 0; i < N4; i++) begin
                addr_q.push_back(m_oc * N4 + i);
                word_q.push_back(word_of(m_oc * N4 + i));
              end
              nx_active = 1'b1;
            end
          end
          m_active = nx_active; m_done_now = nx_done; m_all_now = nx_all; m_oc = nx_oc;
        end
      end
    end
  end

  typedef struct {
    bit load; bit ready; bit rd; int addr; bit valid; int widx; bit busy; bit done; bit all;
  } vec_t;

  vec_t vecs[27];

  task automatic do_reset();
    rst_n = 1'b0; load4 = 1'b0; load1 = 1'b0;
    mon_en = 1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] t_rd, t_valid, t_busy, t_done;
    logic [5:0] bp_pat;
    int ch, k, base;
    // Cycle-relative template for one N=4 channel with ready held high.
    t_rd    = 9'b000011110;
    t_valid = 9'b001111000;
    t_busy  = 9'b001111110;
    t_done  = 9'b010000000;
    for (int b = 0; b < 3; b++) begin
      ch = (b == 1) ? 1 : 0;
      for (int c = 0; c < 9; c++) begin
        k = b * 9 + c;
        vecs[k].load  = (c == 0);
        vecs[k].ready = 1'b1;
        vecs[k].rd    = t_rd[c];
        vecs[k].addr  = ch * N4 + c - 1;
        vecs[k].valid = t_valid[c];
        vecs[k].widx  = ch * N4 + c - 3;
        vecs[k].busy  = t_busy[c];
        vecs[k].done  = t_done[c];
        vecs[k].all   = t_done[c] && (ch == 1);
      end
    end

    rst_n = 1'b0; load4 = 1'b0; load1 = 1'b0;
    bus4.weight_ready = 1'b0; bus1.weight_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_rd_en", bus4.mem_rd_en, 1'b0);
    chk32("reset_addr", 32'(bus4.mem_addr), 32'd0);
    chk1("reset_valid", bus4.weight_valid, 1'b0);
    chk32("reset_wout", bus4.weight_out, 32'd0);
    chk1("reset_busy", busy4, 1'b0);
    chk1("reset_ch_done", done4, 1'b0);
    chk1("reset_all_done", all4, 1'b0);
    chk1("reset_overrun", ovr4, 1'b0);
    chk1("reset_busy_n1", busy1, 1'b0);
    chk1("reset_valid_n1", bus1.weight_valid, 1'b0);
    step();

    // Cycle-exact table: three channels, wrap on the third.
    for (int i = 0; i < 27; i++) begin
      load4 = vecs[i].load;
      bus4.weight_ready = vecs[i].ready;
      @(negedge clk);
      chk1("tbl_rd_en", bus4.mem_rd_en, vecs[i].rd);
      if (vecs[i].rd) chk32("tbl_addr", 32'(bus4.mem_addr), vecs[i].addr);
      chk1("tbl_valid", bus4.weight_valid, vecs[i].valid);
      if (vecs[i].valid) chk32("tbl_word", bus4.weight_out, word_of(vecs[i].widx));
      chk1("tbl_busy", busy4, vecs[i].busy);
      chk1("tbl_ch_done", done4, vecs[i].done);
      chk1("tbl_all_done", all4, vecs[i].all);
      step();
    end
    load4 = 1'b0;

    // Degenerate CHANNEL_NUM_IN=1: one word per request, channel advances each time.
    bus1.weight_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) begin
        load1 = (c == 0);
        @(negedge clk);
        chk1("n1_rd_en", bus1.mem_rd_en, c == 1);
        if (c == 1) chk32("n1_addr", 32'(bus1.mem_addr), r % 2);
        chk1("n1_valid", bus1.weight_valid, c == 3);
        if (c == 3) chk32("n1_word", bus1.weight_out, word_of(r % 2));
        chk1("n1_busy", busy1, (c >= 1) && (c <= 3));
        chk1("n1_ch_done", done1, c == 4);
        chk1("n1_all_done", all1, (c == 4) && (r % 2 == 1));
        step();
      end
    end
    load1 = 1'b0;

    // Backpressure with ready pattern 1,0,0,1,0,1 repeating.
    do_reset();
    bp_pat = 6'b101001;
    for (int c = 0; c < 30; c++) begin
      load4 = (c == 0);
      bus4.weight_ready = bp_pat[c % 6];
      step();
    end
    load4 = 1'b0;
    chk32("bp_drained", 32'(word_q.size()), 32'd0);

    // Full stall from cycle 0, then release.
    do_reset();
    bus4.weight_ready = 1'b0;
    base = issued_cnt;
    load4 = 1'b1;
    step();
    load4 = 1'b0;
    repeat (11) step();
    chk_le("stall_reads", issued_cnt - base, 3);
    chk1("stall_hold_valid", bus4.weight_valid, 1'b1);
    chk32("stall_hold_word", bus4.weight_out, word_of(0));
    bus4.weight_ready = 1'b1;
    repeat (10) step();
    chk32("stall_drained", 32'(word_q.size()), 32'd0);

    // Overrun while busy, then an idle-time request for the next channel.
    do_reset();
    bus4.weight_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      load4 = (c == 0) || (c == 4);
      step();
    end
    chk1("ovr_set", ovr4, 1'b1);
    load4 = 1'b1;
    step();
    load4 = 1'b0;
    repeat (10) step();
    chk1("ovr_sticky", ovr4, 1'b1);
    chk32("ovr_drained", 32'(word_q.size()), 32'd0);

    // Reset mid-stream, then restart from channel 0.
    do_reset();
    for (int c = 0; c < 18; c++) begin
      load4 = (c == 0) || (c == 7);
      rst_n = (c != 5);
      step();
    end
    load4 = 1'b0;
    chk32("rst_mid_drained", 32'(word_q.size()), 32'd0);

    // Random run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus4.weight_ready = ($urandom_range(0, 3) != 0);
      load4 = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    load4 = 1'b0;
    bus4.weight_ready = 1'b1;
    repeat (20) step();
    chk32("rand_drained", 32'(word_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_1x1_weight_streamer.md
Name: conv_1x1_weight_streamer

Overview:
- Weight-side transmitter for the 1x1 convolution top. It fetches the kernel weights for one output channel from a weight memory and streams them as a valid/data sequence onto the top's weight input (valid_weight_in / weight_in).
- A new block of CHANNEL_NUM_IN weights is sent on each load request, which comes from the weight buffer's load_weights.
- The block walks the output channels in order, wraps after the last one, and has a 4-entry output FIFO so the consumer can stall it.

Parameters:
- DATA_WIDTH, 32: weight word width (fp32).
- CHANNEL_NUM_IN, 256: weights per output channel; must be ≥ 1.
- CHANNEL_NUM_OUT, 256: number of output channels before the channel index wraps.
- ADDR_WIDTH, 16: weight memory address width; must satisfy 2^ADDR_WIDTH ≥ CHANNEL_NUM_IN*CHANNEL_NUM_OUT.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- load_req, in, 1: single-cycle request to stream the next output channel's weights.
- mem_rd_en, out, 1: weight memory read strobe.
- mem_addr, out, ADDR_WIDTH: weight memory read address.
- mem_rdata, in, DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
- weight_ready, in, 1: consumer can accept a word.
- weight_valid, out, 1: weight_out holds a valid word.
- weight_out, out, DATA_WIDTH: weight word.
- busy, out, 1: a channel is being streamed.
- ch_done, out, 1: one-cycle pulse when a channel's last word has been transferred.
- all_done, out, 1: one-cycle pulse, coincident with ch_done, when that channel was CHANNEL_NUM_OUT-1.
- req_overrun, out, 1: sticky; set when load_req arrives while busy.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; oc, ic_issue, ic_sent and base_addr are cleared; the FIFO is emptied; the in-flight flag is cleared.
  - All outputs are 0: mem_rd_en, mem_addr, weight_valid, weight_out, busy, ch_done, all_done, req_overrun.
  - Reset mid-stream aborts the stream. Remaining words are discarded and the next request starts again at channel 0.
- States:
  - IDLE: load_req=1 moves to STREAM; ic_issue and ic_sent are set to 0 and busy=1.
  - STREAM: issue reads and drain the FIFO. When ic_sent reaches CHANNEL_NUM_IN on a handshake, move to IDLE, pulse ch_done, then advance the channel.
  - Channel advance:
    - If oc = CHANNEL_NUM_OUT-1: oc goes to 0, base_addr goes to 0, and all_done pulses.
    - Otherwise: oc increments and base_addr increases by CHANNEL_NUM_IN. This is an adder, not a multiplier.
- Read issue:
  - In STREAM, mem_rd_en=1 when both hold: ic_issue < CHANNEL_NUM_IN, and fifo_count + inflight ≤ 2 (registered values).
  - mem_addr = base_addr + ic_issue; ic_issue increments on each issue.
  - mem_rd_en is 0 in IDLE.
- Return path: in the cycle after an issue, mem_rdata is written into the FIFO tail. The credit rule guarantees the FIFO never overflows.
- Output:
  - weight_valid = FIFO not empty; weight_out = FIFO head.
  - A transfer happens when weight_valid & weight_ready; it pops the FIFO and increments ic_sent.
  - A push and a pop in the same cycle is legal and leaves the count unchanged.
  - weight_out holds stable while weight_valid=1 and weight_ready=0.
- Latency: load_req in cycle 0 gives mem_rd_en in cycle 1 (addr = base), mem_rdata in cycle 2, and weight_valid in cycle 3.
- Throughput:
  - With weight_ready held at 1, one word per cycle.
  - The last word is transferred in cycle CHANNEL_NUM_IN+2; ch_done=1 and busy=0 in cycle CHANNEL_NUM_IN+3.
- load_req while busy: the request is ignored, req_overrun is set to 1, and it stays set until reset. A load_req in the same cycle that ch_done is high is also an overrun.
- Order: words leave strictly in ascending ic order. No word is dropped or duplicated under any weight_ready pattern.
- Arithmetic: ic counters are $clog2(CHANNEL_NUM_IN+1) bits wide and do not wrap within a channel. base_addr is ADDR_WIDTH bits.

Test Plan:
- Basic stream, wrap, no stall:
  - Setup: CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2, mem[a]=a, weight_ready=1.
  - load_req at cycle 0 → weights 0,1,2,3 in cycles 3..6; ch_done in cycle 7; all_done=0.
  - A second request → weights 4..7 and all_done=1 with ch_done.
  - A third request → weights 0..3 (wrap).
- Backpressure: weight_ready toggles 1,0,0,1,0,1,... → the same sequence 0..3 with no drops or duplicates. weight_out is stable while stalled, and mem_rd_en never pushes FIFO occupancy above 4.
- Full stall: weight_ready=0 from cycle 0 → at most 3 reads are issued and weight_valid stays 1 holding word 0. Releasing ready drains 0..3 in order.
- Overrun: load_req again in cycle 4 while busy → req_overrun=1 and the stream completes unchanged (0..3). A following idle-time request streams 4..7; req_overrun stays 1.
- Reset mid-stream: reset=0 in cycle 5 → all outputs are 0 the next cycle. A new load_req streams channel 0 (words 0..3).
- Degenerate: CHANNEL_NUM_IN=1 → a single word per request, ch_done in cycle 4, and the channel advances each request.
